mem_dump_streamer: RTL and testbench

MEM_DUMP_STREAMER -- requirements
Module: mem_dump_streamer

---
 rtl/mem_dump_streamer_if.sv | 37 +++
 rtl/mem_dump_streamer.sv | 165 ++++++++++++++++
 tb/tb_mem_dump_streamer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_streamer_if.sv
// Memory read port and output stream of the memory dump streamer.
// The design drives the master side; memory and downstream sink sit on the slave side.
interface mem_dump_streamer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_rdata,
        output out_valid,
        output out_data,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_rdata,
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mem_dump_streamer.sv
// Scans a synchronous-read memory for its highest nonzero word, then streams words 0..last
// out over a valid/ready port (or streams the whole memory when full_mode is set).
module mem_dump_streamer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                full_mode,
    mem_dump_streamer_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [ADDR_W:0]     word_count
);
    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LastAddr = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StScanDrain,
        StRd,
        StWait,
        StFin
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W:0]   addr_q, addr_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] last_nz_q, last_nz_d;
    logic              scan_chk_q;
    logic [ADDR_W-1:0] scan_raddr_q;
    logic              wait_first_q;
    logic [DATA_W-1:0] hold_q;

    logic              hit;
    logic              found_eff;
    logic [ADDR_W-1:0] last_nz_eff;
    logic              last_beat;

    // Scan data returns one cycle after its address, so the last word lands in SCAN_DRAIN.
    always_comb begin
        hit         = scan_chk_q && (bus.mem_rdata != '0);
        found_eff   = found_q | hit;
        last_nz_eff = hit ? scan_raddr_q : last_nz_q;
        last_beat   = (addr_q == (wc_q - CntOne));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wc_d      = wc_q;
        found_d   = found_eff;
        last_nz_d = last_nz_eff;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d    = '0;
                    last_nz_d = '0;
                    if (full_mode) begin
                        state_d = StRd;
                        wc_d    = DepthCnt;
                        found_d = 1'b1;
                    end else begin
                        state_d = StScan;
                        wc_d    = '0;
                        found_d = 1'b0;
                    end
                end
            end
            StScan: begin
                addr_d = addr_q + CntOne;
                if (addr_q == LastAddr) begin
                    state_d = StScanDrain;
                end
            end
            StScanDrain: begin
                addr_d = '0;
                if (found_eff) begin
                    wc_d    = {1'b0, last_nz_eff} + CntOne;
                    state_d = StRd;
                end else begin
                    wc_d    = '0;
                    state_d = StFin;
                end
            end
            StRd: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.out_ready) begin
                    if (last_beat) begin
                        state_d = StFin;
                    end else begin
                        addr_d  = addr_q + CntOne;
                        state_d = StRd;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            wc_q         <= '0;
            found_q      <= 1'b0;
            last_nz_q    <= '0;
            scan_chk_q   <= 1'b0;
            scan_raddr_q <= '0;
            wait_first_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            addr_q       <= addr_d;
            wc_q         <= wc_d;
            found_q      <= found_d;
            last_nz_q    <= last_nz_d;
            scan_chk_q   <= (state_q == StScan);
            scan_raddr_q <= addr_q[ADDR_W-1:0];
            wait_first_q <= (state_q == StRd);
            if ((state_q == StWait) && wait_first_q) begin
                hold_q <= bus.mem_rdata;
            end
        end
    end

    // First WAIT cycle forwards the fresh read data; later stall cycles replay the held copy.
    always_comb begin
        busy          = (state_q != StIdle);
        done          = (state_q == StFin);
        found         = found_q;
        word_count    = wc_q;
        bus.mem_en    = (state_q == StScan) || (state_q == StRd);
        bus.mem_addr  = bus.mem_en ? addr_q[ADDR_W-1:0] : '0;
        bus.out_valid = (state_q == StWait);
        bus.out_addr  = '0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        if (state_q == StWait) begin
            bus.out_addr = addr_q[ADDR_W-1:0];
            bus.out_last = last_beat;
            bus.out_data = wait_first_q ? bus.mem_rdata : hold_q;
        end
    end
endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer: expected beats go into a scoreboard queue at stimulus
// time and a negedge monitor pops and compares them on every handshake.
module tb_mem_dump_streamer;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 9;
    localparam int          DEPTH = 512;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          full_mode;
    logic          busy;
    logic          done;
    logic          found;
    logic [AW:0]   word_count;
    logic [DW-1:0] mem [DEPTH];

    beat_t sb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int first_en_cyc = 0;
    int done_cnt = 0;
    int en_cnt = 0;
    int beat_cnt = 0;
    int valid_cnt = 0;

    mem_dump_streamer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_dump_streamer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .full_mode  (full_mode),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    initial begin : monitor
        beat_t exp_b;
        beat_t got_b;
        beat_t prev_b;
        logic  stall;
        stall  = 1'b0;
        prev_b = '0;
        forever begin
            @(negedge clk);
            cyc++;
            got_b = {bus.out_data, bus.out_addr, bus.out_last};
            if (stall) begin
                checks++;
                if (!bus.out_valid || got_b != prev_b) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%0b data=%h addr=%0d last=%0b, need valid=1 data=%h addr=%0d last=%0b",
                             bus.out_valid, got_b.data, got_b.addr, got_b.last,
                             prev_b.data, prev_b.addr, prev_b.last);
                end
            end
            if (start && !busy && !rst) begin
                start_cyc    = cyc;
                first_en_cyc = 0;
            end else if (bus.mem_en && first_en_cyc == 0) begin
                first_en_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.mem_en) en_cnt++;
            if (bus.out_valid) valid_cnt++;
            if (bus.out_valid && bus.out_ready && !rst) begin
                beat_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got data=%h addr=%0d last=%0b, need no beat",
                             got_b.data, got_b.addr, got_b.last);
                end else begin
                    exp_b = sb.pop_front();
                    if (got_b != exp_b) begin
                        failures++;
                        $display("FAIL beat: got data=%h addr=%0d last=%0b, need data=%h addr=%0d last=%0b",
                                 got_b.data, got_b.addr, got_b.last,
                                 exp_b.data, exp_b.addr, exp_b.last);
                    end
                end
            end
            stall  = bus.out_valid && !bus.out_ready && !rst;
            prev_b = got_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, need %0d", name, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    task automatic push_range(input int lo, input int hi, input int wc);
        beat_t b;
        for (int i = lo; i <= hi; i++) begin
            b.data = mem[i];
            b.addr = AW'(i);
            b.last = (i == wc - 1);
            sb.push_back(b);
        end
    endtask

    task automatic do_start(input logic fm);
        start     = 1'b1;
        full_mode = fm;
        tick();
        start     = 1'b0;
        full_mode = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base, input int budget);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (done_cnt == base) begin
            failures++;
            $display("FAIL %s_done_timeout: got no done in %0d cycles, need a done pulse", name, budget);
        end
    endtask

    task automatic wait_beat_addr(input string name, input int a, input int budget);
        int n;
        n = 0;
        while (!(bus.out_valid && bus.out_addr == AW'(a)) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!(bus.out_valid && bus.out_addr == AW'(a))) begin
            failures++;
            $display("FAIL %s_beat_timeout: got no valid beat at addr %0d, need one", name, a);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctrl"}, {busy, done, found, word_count, bus.mem_en, bus.mem_addr}, 0);
        check({name, "_stream"}, {bus.out_valid, bus.out_addr, bus.out_last}, 0);
        check({name, "_out_data"}, bus.out_data, 0);
    endtask

    task automatic check_end(input string name, input int exp_wc, input int exp_found,
                             input int exp_beats, input int bd, input int bb);
        repeat (3) tick();
        check({name, "_word_count"}, word_count, exp_wc);
        check({name, "_found"}, found, exp_found);
        check({name, "_beats"}, beat_cnt - bb, exp_beats);
        check({name, "_sb_left"}, sb.size(), 0);
        check({name, "_done_pulses"}, done_cnt - bd, 1);
        check({name, "_busy_after"}, busy, 0);
        sb.delete();
    endtask

    initial begin : stimulus
        int bd, bb, be, bv;
        rst           = 1'b1;
        start         = 1'b0;
        full_mode     = 1'b0;
        bus.out_ready = 1'b1;
        clear_mem();
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Words 0..13 nonzero: 513 scan cycles, 14 two-cycle beats, FIN at start+542.
        clear_mem();
        for (int i = 0; i < 14; i++) mem[i] = 32'hA500_0000 + 32'(i) + 32'd1;
        push_range(0, 13, 14);
        bd = done_cnt; bb = beat_cnt; be = en_cnt;
        do_start(1'b0);
        wait_done("t1", bd, 2000);
        check("t1_done_latency", done_cyc - start_cyc, 542);
        check("t1_mem_en_cycles", en_cnt - be, 526);
        check_end("t1", 14, 1, 14, bd, bb);

        // All zero: no beats, done at start+514.
        clear_mem();
        bd = done_cnt; bb = beat_cnt; be = en_cnt; bv = valid_cnt;
        do_start(1'b0);
        wait_done("t2", bd, 2000);
        check("t2_done_latency", done_cyc - start_cyc, 514);
        check("t2_valid_cycles", valid_cnt - bv, 0);
        check("t2_mem_en_cycles", en_cnt - be, 512);
        check_end("t2", 0, 0, 0, bd, bb);

        // Only ends nonzero: full 512-word stream including 510 zero words.
        clear_mem();
        mem[0]   = 32'h0000_0001;
        mem[511] = 32'hDEAD_BEEF;
        push_range(0, 511, 512);
        bd = done_cnt; bb = beat_cnt;
        do_start(1'b0);
        wait_done("t3", bd, 3000);
        check("t3_done_latency", done_cyc - start_cyc, 1538);
        check_end("t3", 512, 1, 512, bd, bb);

        // Backpressure for 10 cycles on beat 2.
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = 32'h1111_1111 * 32'(i + 1);
        push_range(0, 3, 4);
        bd = done_cnt; bb = beat_cnt;
        do_start(1'b0);
        wait_beat_addr("t4", 2, 1000);
        bus.out_ready = 1'b0;
        repeat (10) tick();
        bus.out_ready = 1'b1;
        wait_done("t4", bd, 1000);
        check("t4_done_latency", done_cyc - start_cyc, 532);
        check_end("t4", 4, 1, 4, bd, bb);

        // Reset while stalled at beat 5, then a fresh dump.
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = 32'h5000_0000 | 32'(i * 17 + 3);
        push_range(0, 4, 10);
        bb = beat_cnt;
        do_start(1'b0);
        wait_beat_addr("t5", 5, 1000);
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        tick();
        check_zero("t5_rst");
        check("t5_beats_before_rst", beat_cnt - bb, 5);
        check("t5_sb_left_rst", sb.size(), 0);
        sb.delete();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        push_range(0, 9, 10);
        bd = done_cnt; bb = beat_cnt;
        do_start(1'b0);
        wait_done("t5", bd, 2000);
        check("t5_done_latency", done_cyc - start_cyc, 534);
        check_end("t5", 10, 1, 10, bd, bb);

        // Full mode with stray start pulses while busy.
        for (int i = 0; i < DEPTH; i++)
            mem[i] = (i % 7 == 3) ? 32'h0 : (32'hC000_0000 ^ (32'(i) * 32'h0001_0003));
        push_range(0, 511, 512);
        bd = done_cnt; bb = beat_cnt; be = en_cnt;
        do_start(1'b1);
        repeat (40) tick();
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (100) tick();
        end
        wait_done("t6", bd, 2000);
        check("t6_first_mem_en", first_en_cyc - start_cyc, 1);
        check("t6_done_latency", done_cyc - start_cyc, 1025);
        check("t6_mem_en_cycles", en_cnt - be, 512);
        check_end("t6", 512, 1, 512, bd, bb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
